// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: one-cycle compare-branch resolution with a 2-bit predictor.
// Define BRANCH_SIGNED_CMP_EN for signed bgt/bgte/ble/bleq compares.
module branch_resolve_unit #(
  parameter int PC_W       = 9,
  parameter int DATA_W     = 32,
  parameter int PRED_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_reg,
  input  logic [PC_W-1:0]   PC,
  input  logic              pred_in,
  input  logic [DATA_W-1:0] reg_1,
  input  logic [DATA_W-1:0] reg_2,
  input  logic [PC_W-1:0]   predict_pc,
  output logic              predict_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   new_PC,
  output logic              taken,
  output logic              is_branch,
  output logic              mispredict,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int IDX_W = $clog2(PRED_DEPTH);
  localparam int TGT_W = (PC_W < 16) ? PC_W : 16;

  localparam logic [5:0] OP_BEQ  = 6'd15;
  localparam logic [5:0] OP_BNE  = 6'd16;
  localparam logic [5:0] OP_BGT  = 6'd17;
  localparam logic [5:0] OP_BGTE = 6'd18;
  localparam logic [5:0] OP_BLE  = 6'd19;
  localparam logic [5:0] OP_BLEQ = 6'd20;

  localparam logic [1:0] CTR_INIT = 2'b01;
  localparam logic [1:0] CTR_MAX  = 2'b11;
  localparam logic [1:0] CTR_MIN  = 2'b00;

  localparam logic [CNT_W-1:0] STAT_MAX = '1;

  logic [5:0]       w_opc;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;
  logic             w_taken;
  logic             w_is_br;
  logic             w_mis;
  logic             w_fire;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_next_pc;
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_lkp_idx;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_nxt;
  logic             w_unused_bits;

  logic [1:0]       r_tbl [PRED_DEPTH];
  logic             r_out_valid;
  logic [PC_W-1:0]  r_new_pc;
  logic             r_taken;
  logic             r_is_branch;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_mis_cnt;

  assign w_opc = inst_reg[31:26];
  assign w_unused_bits = ^{inst_reg, predict_pc, PC};

  assign in_ready = !r_out_valid || out_ready;
  assign w_fire   = in_valid && in_ready;

  // Ordering compares; equality is sign-agnostic.
  assign w_eq = (reg_1 == reg_2);
`ifdef BRANCH_SIGNED_CMP_EN
  assign w_gt = $signed(reg_1) > $signed(reg_2);
  assign w_lt = $signed(reg_1) < $signed(reg_2);
`else
  assign w_gt = reg_1 > reg_2;
  assign w_lt = reg_1 < reg_2;
`endif

  always_comb begin
    w_is_br = 1'b1;
    w_taken = 1'b0;
    case (w_opc)
      OP_BEQ:  w_taken = w_eq;
      OP_BNE:  w_taken = !w_eq;
      OP_BGT:  w_taken = w_gt;
      OP_BGTE: w_taken = !w_lt;
      OP_BLE:  w_taken = w_lt;
      OP_BLEQ: w_taken = !w_gt;
      default: w_is_br = 1'b0;
    endcase
  end

  always_comb begin
    w_target = '0;
    w_target[TGT_W-1:0] = inst_reg[TGT_W-1:0];
  end

  assign w_next_pc = w_taken ? w_target : PC;
  assign w_mis     = w_taken ^ pred_in;

  assign w_upd_idx = PC[IDX_W-1:0];
  assign w_lkp_idx = predict_pc[IDX_W-1:0];
  assign w_ctr_cur = r_tbl[w_upd_idx];

  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    if (w_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_nxt = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != CTR_MIN) w_ctr_nxt = w_ctr_cur - 2'd1;
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not seen.
  assign predict_taken = r_tbl[w_lkp_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PRED_DEPTH; i++) r_tbl[i] <= CTR_INIT;
    end else if (w_fire && w_is_br) begin
      r_tbl[w_upd_idx] <= w_ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_new_pc     <= '0;
      r_taken      <= 1'b0;
      r_is_branch  <= 1'b0;
      r_mispredict <= 1'b0;
    end else if (w_fire) begin
      r_out_valid  <= 1'b1;
      r_new_pc     <= w_next_pc;
      r_taken      <= w_taken;
      r_is_branch  <= w_is_br;
      r_mispredict <= w_mis;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis_cnt <= '0;
    end else if (w_fire && w_mis && (r_mis_cnt != STAT_MAX)) begin
      r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  assign out_valid      = r_out_valid;
  assign new_PC         = r_new_pc;
  assign taken          = r_taken;
  assign is_branch      = r_is_branch;
  assign mispredict     = r_mispredict;
  assign mispredict_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference of the branch resolution rules.
module tb_branch_resolve_unit;

  localparam int PC_W   = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       inst_reg;
  logic [PC_W-1:0]   PC;
  logic              pred_in;
  logic [DATA_W-1:0] reg_1;
  logic [DATA_W-1:0] reg_2;
  logic [PC_W-1:0]   predict_pc;
  logic              predict_taken;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   new_PC;
  logic              taken;
  logic              is_branch;
  logic              mispredict;
  logic [CNT_W-1:0]  mispredict_cnt;

  branch_resolve_unit #(
    .PC_W(PC_W), .DATA_W(DATA_W), .PRED_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_reg(inst_reg), .PC(PC), .pred_in(pred_in),
    .reg_1(reg_1), .reg_2(reg_2),
    .predict_pc(predict_pc), .predict_taken(predict_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .new_PC(new_PC), .taken(taken), .is_branch(is_branch),
    .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int pc;
    bit tk;
    bit br;
    bit mis;
  } res_t;

  function automatic bit m_taken(int opc, logic [31:0] a, logic [31:0] b);
    longint x, y;
`ifdef BRANCH_SIGNED_CMP_EN
    x = longint'($signed(a));
    y = longint'($signed(b));
`else
    x = longint'(a);
    y = longint'(b);
`endif
    case (opc)
      15: return x == y;
      16: return x != y;
      17: return x > y;
      18: return x >= y;
      19: return x < y;
      20: return x <= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_in(int opc, int tgt, int pc, bit pr,
                        logic [31:0] a, logic [31:0] b);
    logic [5:0]  o;
    logic [15:0] t;
    o = opc[5:0];
    t = tgt[15:0];
    inst_reg = {o, 10'd0, t};
    PC       = pc[PC_W-1:0];
    pred_in  = pr;
    reg_1    = a;
    reg_2    = b;
    in_valid = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    set_in(15, 'h40, 12, 0, 5, 5);
    predict_pc = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (new_PC !== '0) $display("FAIL reset new_PC got %h want 0", new_PC);
    else n_pass++;
    n_checks++;
    if ({taken, is_branch, mispredict} !== 3'b000)
      $display("FAIL reset flags got %b want 000", {taken, is_branch, mispredict});
    else n_pass++;
    n_checks++;
    if (mispredict_cnt !== '0) $display("FAIL reset cnt got %0d want 0", mispredict_cnt);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      predict_pc = PC_W'(i);
      #1;
      n_checks++;
      if (predict_taken !== 1'b0)
        $display("FAIL reset predict idx %0d got %b want 0", i, predict_taken);
      else n_pass++;
    end
  endtask

  task automatic test_beq_taken();
    apply_reset();
    set_in(15, 'h40, 12, 0, 5, 5);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL beq early out_valid got %b want 0", out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL beq out_valid got %b want 1", out_valid);
    else n_pass++;
    n_checks++;
    if (taken !== 1'b1 || is_branch !== 1'b1)
      $display("FAIL beq taken/is_branch got %b%b want 11", taken, is_branch);
    else n_pass++;
    n_checks++;
    if (new_PC !== 9'h040) $display("FAIL beq new_PC got %h want 040", new_PC);
    else n_pass++;
    n_checks++;
    if (mispredict !== 1'b1) $display("FAIL beq mispredict got %b want 1", mispredict);
    else n_pass++;
    n_checks++;
    if (mispredict_cnt !== 16'd1) $display("FAIL beq cnt got %0d want 1", mispredict_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL beq drain out_valid got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_training();
    apply_reset();
    predict_pc = 9'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in(15, 'h20, 3, 0, 7, 7);
      #1;
      if (k == 0) begin
        n_checks++;
        if (predict_taken !== 1'b0)
          $display("FAIL collide pre-update got %b want 0", predict_taken);
        else n_pass++;
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        n_checks++;
        if (predict_taken !== 1'b1)
          $display("FAIL collide post-update got %b want 1", predict_taken);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (predict_taken !== 1'b1) $display("FAIL train taken got %b want 1", predict_taken);
    else n_pass++;
    n_checks++;
    if (mispredict_cnt !== 16'd3) $display("FAIL train cnt got %0d want 3", mispredict_cnt);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_in(15, 'h20, 3, 0, 7, 8);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (new_PC !== 9'd3) $display("FAIL train nt new_PC got %h want 003", new_PC);
    else n_pass++;
    n_checks++;
    if (predict_taken !== 1'b0) $display("FAIL train nt got %b want 0", predict_taken);
    else n_pass++;
    n_checks++;
    if (mispredict_cnt !== 16'd3) $display("FAIL train nt cnt got %0d want 3", mispredict_cnt);
    else n_pass++;
    @(negedge clk);
    set_in(15, 'h20, 3, 1, 1, 1);
    @(posedge clk);
    #1;
    n_checks++;
    if (predict_taken !== 1'b0) $display("FAIL train floor got %b want 0", predict_taken);
    else n_pass++;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (predict_taken !== 1'b1) $display("FAIL train regrow got %b want 1", predict_taken);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    set_in(15, 'h40, 12, 1, 5, 5);
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL bp stall got v%b r%b want v1 r0", out_valid, in_ready);
    else n_pass++;
    set_in(16, 'h1ff, 5, 1, 9, 9);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || new_PC !== 9'h040 || taken !== 1'b1 || mispredict !== 1'b0)
        $display("FAIL bp hold got r%b pc%h t%b m%b want r0 pc040 t1 m0",
                 in_ready, new_PC, taken, mispredict);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp release in_ready got %b want 1", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || new_PC !== 9'd5 || taken !== 1'b0 || mispredict !== 1'b1)
      $display("FAIL bp second got v%b pc%h t%b m%b want v1 pc005 t0 m1",
               out_valid, new_PC, taken, mispredict);
    else n_pass++;
    n_checks++;
    if (mispredict_cnt !== 16'd1) $display("FAIL bp cnt got %0d want 1", mispredict_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp drain got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_signed();
    bit exp_tk;
`ifdef BRANCH_SIGNED_CMP_EN
    exp_tk = 1'b0;
`else
    exp_tk = 1'b1;
`endif
    apply_reset();
    set_in(17, 'h10, 20, 0, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (taken !== exp_tk) $display("FAIL signed bgt taken got %b want %b", taken, exp_tk);
    else n_pass++;
    n_checks++;
    if (new_PC !== (exp_tk ? 9'h010 : 9'd20))
      $display("FAIL signed bgt new_PC got %h", new_PC);
    else n_pass++;
  endtask

  task automatic test_nonbranch();
    apply_reset();
    set_in(3, 'h33, 7, 1, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (is_branch !== 1'b0 || taken !== 1'b0)
      $display("FAIL nonbr flags got br%b t%b want 00", is_branch, taken);
    else n_pass++;
    n_checks++;
    if (new_PC !== 9'd7) $display("FAIL nonbr new_PC got %h want 007", new_PC);
    else n_pass++;
    n_checks++;
    if (mispredict !== 1'b1 || mispredict_cnt !== 16'd1)
      $display("FAIL nonbr mis got %b cnt %0d want 1 1", mispredict, mispredict_cnt);
    else n_pass++;
    predict_pc = 9'd7;
    #1;
    n_checks++;
    if (predict_taken !== 1'b0) $display("FAIL nonbr table got %b want 0", predict_taken);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    out_ready = 1'b0;
    set_in(15, 'h40, 12, 0, 5, 5);
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL midrst pre got %b want 1", out_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || new_PC !== '0 || taken !== 1'b0 || mispredict_cnt !== '0)
      $display("FAIL midrst got v%b pc%h t%b c%0d want all 0",
               out_valid, new_PC, taken, mispredict_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL midrst in_ready got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_random();
    res_t q[$];
    res_t r;
    int   m_tbl[DEPTH];
    int   m_cnt;
    int   opc, pc, tgt;
    bit   pr, exp_rdy, acc;
    logic [31:0] a, b;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
    m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      opc = int'($urandom_range(12, 23));
      pc  = int'($urandom_range(0, 511));
      tgt = int'($urandom_range(0, 65535));
      pr  = 1'($urandom_range(0, 1));
      a   = $urandom();
      b   = $urandom();
      if ($urandom_range(0, 1) == 1) a = a & 32'h8000_0003;
      if ($urandom_range(0, 1) == 1) b = b & 32'h8000_0003;
      if ($urandom_range(0, 3) == 0) b = a;
      set_in(opc, tgt, pc, pr, a, b);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      predict_pc = ($urandom_range(0, 1) == 1) ? PC : PC_W'($urandom_range(0, 511));
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      n_checks++;
      if (in_ready !== exp_rdy) $display("FAIL rnd in_ready got %b want %b", in_ready, exp_rdy);
      else n_pass++;
      n_checks++;
      if (out_valid !== (q.size() != 0))
        $display("FAIL rnd out_valid got %b want %b", out_valid, q.size() != 0);
      else n_pass++;
      if (q.size() != 0) begin
        n_checks++;
        if (int'(new_PC) != q[0].pc || taken !== q[0].tk ||
            is_branch !== q[0].br || mispredict !== q[0].mis)
          $display("FAIL rnd result got pc%0d t%b b%b m%b want pc%0d t%b b%b m%b",
                   new_PC, taken, is_branch, mispredict,
                   q[0].pc, q[0].tk, q[0].br, q[0].mis);
        else n_pass++;
      end
      n_checks++;
      if (predict_taken !== (m_tbl[int'(predict_pc) % DEPTH] >= 2))
        $display("FAIL rnd predict idx %0d got %b", int'(predict_pc) % DEPTH, predict_taken);
      else n_pass++;
      n_checks++;
      if (int'(mispredict_cnt) != m_cnt)
        $display("FAIL rnd cnt got %0d want %0d", mispredict_cnt, m_cnt);
      else n_pass++;
      @(posedge clk);
      acc = in_valid && exp_rdy;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        r.br  = (opc >= 15 && opc <= 20);
        r.tk  = m_taken(opc, a, b);
        r.pc  = r.tk ? (tgt % (1 << PC_W)) : pc;
        r.mis = r.tk ^ pr;
        q.push_back(r);
        if (r.mis && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (r.br) begin
          if (r.tk && m_tbl[pc % DEPTH] < 3) m_tbl[pc % DEPTH]++;
          if (!r.tk && m_tbl[pc % DEPTH] > 0) m_tbl[pc % DEPTH]--;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    inst_reg = '0;
    PC = '0;
    pred_in = 1'b0;
    reg_1 = '0;
    reg_2 = '0;
    predict_pc = '0;
    test_reset();
    test_beq_taken();
    test_training();
    test_backpressure();
    test_signed();
    test_nonbranch();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage with a built-in 2-bit saturating-counter predictor table. It sits between register read and PC update, accepts one decoded instruction per cycle over a valid/ready handshake, and evaluates the six compare-branch opcodes (15..20). One cycle later it returns the resolved next PC, the taken flag and a mispredict flag against the fetch-time prediction. It also serves combinational prediction lookups to fetch.

## Interface
- `PC_W`, 9: program-counter width in bits.
- `DATA_W`, 32: operand width in bits.
- `PRED_DEPTH`, 16: predictor entries; power of two, ≥2.
- `CNT_W`, 16: width of the mispredict statistics counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction presented.
- `in_ready`  out  1  stage can accept.
- `inst_reg`  in  32  instruction word; opcode `[31:26]`, target `[15:0]`.
- `PC`  in  PC_W  fall-through PC of this instruction.
- `pred_in`  in  1  prediction fetch used for this instruction.
- `reg_1`, `reg_2`  in  DATA_W  compare operands.
- `predict_pc`  in  PC_W  fetch lookup address.
- `predict_taken`  out  1  combinational prediction for `predict_pc`.
- `out_valid`  in/out: out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `new_PC`  out  PC_W  resolved next PC.
- `taken`  out  1  branch taken.
- `is_branch`  out  1  instruction was opcode 15..20.
- `mispredict`  out  1  `pred_in` disagreed with the resolved outcome.
- `mispredict_cnt`  out  CNT_W  saturating count of mispredicts.

## Operation
- **Accept.** A transfer happens when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`.
- **Opcodes.**
  - 15 beq: `reg_1 == reg_2`.
  - 16 bne: `reg_1 != reg_2`.
  - 17 bgt: `reg_1 > reg_2`.
  - 18 bgte: `reg_1 >= reg_2`.
  - 19 ble: `reg_1 < reg_2`.
  - 20 bleq: `reg_1 <= reg_2`.
  - All other opcodes: `is_branch = 0`, `taken = 0`.
- **Next PC.**
  - If `taken`, `new_PC = inst_reg[15:0]`, truncated or zero-extended to `PC_W`.
  - Otherwise `new_PC = PC`.
- **Mispredict.** `mispredict = taken ^ pred_in`. This covers non-branches: a non-branch predicted taken is a mispredict.
- **Predictor.**
  - Index is `PC[log2(PRED_DEPTH)-1:0]`.
  - `predict_taken = table[predict_pc index][1]`.
- **Predictor update.** On each accepted branch (`is_branch = 1`), update the indexed counter:
  - taken: increment, saturating at 3;
  - not taken: decrement, saturating at 0.
  - Non-branches never update the table.
- **Statistics.** `mispredict_cnt` increments by 1 on each accepted mispredict and saturates at all-ones.

## Timing
- **Latency.** Exactly 1 cycle. Result registers load on the accept edge, and `out_valid` rises the next cycle.
- **Backpressure.**
  - When `out_valid && !out_ready`, all result outputs hold stable and `in_ready = 0`.
  - Full throughput of one instruction per cycle is sustained while `out_ready = 1`.
- **Lookup/update collision.** If a lookup and an update hit the same index in the same cycle, `predict_taken` returns the pre-update value. The new value is visible the next cycle.
- **Reset.** While `rst` is high it dominates everything else. On the reset edge:
  - `out_valid`, `new_PC`, `taken`, `is_branch`, `mispredict` and `mispredict_cnt` go to 0;
  - every table entry goes to 2'b01 (weakly not-taken);
  - a result pending mid-transfer is discarded.
- **`in_ready` in reset.** `in_ready` is 1 the cycle after reset deasserts.
- **Counter saturation.** At its maximum value, `mispredict_cnt` stays at maximum, and further mispredicts do not wrap.

## Configuration
- **`BRANCH_SIGNED_CMP_EN` defined:** opcodes 17..20 compare `reg_1`/`reg_2` as two's-complement signed values.
- **`BRANCH_SIGNED_CMP_EN` not defined:** opcodes 17..20 compare as unsigned.
- **Unaffected by the macro:** beq/bne and all other behaviour.

## Test plan
- **Reset defaults.** Assert `rst` 1 cycle → all outputs 0. `predict_taken = 0` for every index. `in_ready = 1` after deassert.
- **beq taken.** `inst_reg` opcode 15, target 0x0040, `PC = 9'd12`, `reg_1 = reg_2 = 5`, `pred_in = 0` → next cycle `out_valid = 1`, `taken = 1`, `new_PC = 9'h040`, `mispredict = 1`, `mispredict_cnt = 1`.
- **Counter training.** Three taken branches at `PC = 3`, then lookup `predict_pc = 3` → `predict_taken = 1`. After four not-taken branches at `PC = 3` → `predict_taken = 0`, and the counter is held at 0.
- **Backpressure.** Hold `out_ready = 0` with back-to-back inputs → `in_ready = 0` from the second cycle; the first result stays stable. Release → results drain in order with no loss or duplication.
- **Signed mode.** bgt with `reg_1 = 32'hFFFF_FFFF`, `reg_2 = 1` → `taken = 0` when the macro is defined, `taken = 1` when it is not.
- **Non-branch and reset mid-flight.**
  - opcode 3, `pred_in = 1`, `PC = 7` → `is_branch = 0`, `new_PC = 7`, `mispredict = 1`, table unchanged.
  - Assert `rst` while `out_valid = 1` → `out_valid = 0` the next cycle.
